// File: rtl/mac_array_sequencer_if.sv
// Host command and line-controller signal bundle for mac_array_sequencer.
// The master side is the host / line controllers; the slave side is the sequencer.
interface mac_array_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_set;
    logic [4:0] cmd_sl_addr;
    logic [4:0] cmd_wl_addr;
    logic       work_en;
    logic       work_mode;
    logic       op_mode;
    logic [4:0] sl_addr_in;
    logic [4:0] wl_addr;
    logic       sl_assert_en;
    logic       bl_assert_en;
    logic       wl_pulse_en;
    logic       op_down;
    logic       busy;
    logic       err_timeout;

    modport master (
        output cmd_valid, cmd_write, cmd_set, cmd_sl_addr, cmd_wl_addr,
        output sl_assert_en, bl_assert_en,
        input  cmd_ready, work_en, work_mode, op_mode, sl_addr_in, wl_addr,
        input  wl_pulse_en, op_down, busy, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_set, cmd_sl_addr, cmd_wl_addr,
        input  sl_assert_en, bl_assert_en,
        output cmd_ready, work_en, work_mode, op_mode, sl_addr_in, wl_addr,
        output wl_pulse_en, op_down, busy, err_timeout
    );
endinterface

// File: rtl/mac_array_sequencer.sv
// Queues single-cell array commands and sequences work_en, line-driver arming,
// the timed WL pulse and the op_down handshake. All outputs are registered.
module mac_array_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  WR_PULSE    = 8'd20,
    parameter logic [7:0]  RD_PULSE    = 8'd40,
    parameter logic [7:0]  ARM_TIMEOUT = 8'd64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    mac_array_sequencer_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    typedef struct packed {
        logic       wr;
        logic       set;
        logic [4:0] sl;
        logic [4:0] wl;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    cmd_t             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             push_s;
    logic             pop_s;
    cmd_t             head_s;

    state_t           state_r;
    state_t           state_next_s;
    logic [7:0]       timer_r;
    logic [7:0]       timer_next_s;
    logic             timeout_s;

    logic             cmd_ready_r;
    logic             work_en_r;
    logic             work_mode_r;
    logic             op_mode_r;
    logic [4:0]       sl_addr_r;
    logic [4:0]       wl_addr_r;
    logic             wl_pulse_en_r;
    logic             op_down_r;
    logic             busy_r;
    logic             err_timeout_r;

    // Queue handshake decode and next occupancy.
    always_comb begin
        push_s       = bus.cmd_valid && cmd_ready_r;
        pop_s        = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
        head_s       = fifo_mem_r[rd_ptr_r];
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Command queue storage, pointers and the registered ready flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_r[i] <= {$bits(cmd_t){1'b0}};
            end
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.cmd_write, bus.cmd_set, bus.cmd_sl_addr, bus.cmd_wl_addr};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Operation sequencing: next state and cycle timer.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (work_mode_r) begin
                    state_next_s = ST_ARM;
                    timer_next_s = ARM_TIMEOUT;
                end else begin
                    state_next_s = ST_PULSE;
                    timer_next_s = RD_PULSE;
                end
            end
            ST_ARM: begin
                // Both drivers must be up in the same cycle; the last timer tick aborts.
                if (bus.sl_assert_en && bus.bl_assert_en) begin
                    state_next_s = ST_PULSE;
                    timer_next_s = WR_PULSE;
                end else if (timer_r <= 8'd1) begin
                    state_next_s = ST_DONE;
                    timer_next_s = 8'd0;
                    timeout_s    = 1'b1;
                end else begin
                    timer_next_s = timer_r - 8'd1;
                end
            end
            ST_PULSE: begin
                if (timer_r <= 8'd1) begin
                    state_next_s = ST_DONE;
                    timer_next_s = 8'd0;
                end else begin
                    timer_next_s = timer_r - 8'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                timer_next_s = 8'd0;
            end
        endcase
    end

    // State and timer registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
        end
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work_en_r     <= 1'b0;
            work_mode_r   <= 1'b0;
            op_mode_r     <= 1'b0;
            sl_addr_r     <= 5'd0;
            wl_addr_r     <= 5'd0;
            wl_pulse_en_r <= 1'b0;
            op_down_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            if (pop_s) begin
                work_mode_r <= head_s.wr;
                op_mode_r   <= head_s.set;
                sl_addr_r   <= head_s.sl;
                wl_addr_r   <= head_s.wl;
            end
            work_en_r     <= (state_next_s == ST_ISSUE);
            wl_pulse_en_r <= (state_next_s == ST_PULSE);
            op_down_r     <= (state_next_s == ST_DONE);
            busy_r        <= (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
            err_timeout_r <= err_timeout_r | timeout_s;
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.work_en     = work_en_r;
    assign bus.work_mode   = work_mode_r;
    assign bus.op_mode     = op_mode_r;
    assign bus.sl_addr_in  = sl_addr_r;
    assign bus.wl_addr     = wl_addr_r;
    assign bus.wl_pulse_en = wl_pulse_en_r;
    assign bus.op_down     = op_down_r;
    assign bus.busy        = busy_r;
    assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed + randomized bench for mac_array_sequencer; each operation is scored
// against timing/outcome predicted from the command rules and driver delays.
module tb_mac_array_sequencer;
    localparam int WR    = 20;
    localparam int RD    = 40;
    localparam int ARM   = 64;
    localparam int DEPTH = 4;

    typedef struct { bit wr; bit st; bit [4:0] sl; bit [4:0] wl; } cmd_t;
    typedef struct { int cyc; logic wm; logic om; logic [4:0] sl; logic [4:0] wl; } we_t;
    typedef struct { int cyc; int plen; int pstart; logic err; logic wm; logic om; logic [4:0] sl; logic [4:0] wl; } dn_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int   sl_dly = -1;
    int   bl_dly = -1;
    int   drop_dly = -1;
    bit   err_model = 1'b0;
    int   last_done = -1;

    cmd_t exp_q[$];
    we_t  we_q[$];
    dn_t  done_q[$];
    int   plen = 0;
    int   pstart = 0;

    mac_array_sequencer_if bus_if ();

    mac_array_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .WR_PULSE   (8'd20),
        .RD_PULSE   (8'd40),
        .ARM_TIMEOUT(8'd64)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records work_en, WL pulse extent and op_down.
    always @(negedge clk) begin
        if (!rst_n) begin
            plen <= 0;
        end else begin
            if (bus_if.work_en)
                we_q.push_back('{cyc, bus_if.work_mode, bus_if.op_mode, bus_if.sl_addr_in, bus_if.wl_addr});
            if (bus_if.op_down) begin
                done_q.push_back('{cyc, plen, pstart, bus_if.err_timeout, bus_if.work_mode,
                                   bus_if.op_mode, bus_if.sl_addr_in, bus_if.wl_addr});
                plen <= 0;
            end else if (bus_if.wl_pulse_en) begin
                if (plen == 0) pstart <= cyc;
                plen <= plen + 1;
            end
        end
    end

    // Line-controller stand-in: raises sl/bl a set number of cycles after work_en.
    initial begin
        int cnt;
        cnt = -1;
        bus_if.sl_assert_en = 1'b0;
        bus_if.bl_assert_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = -1;
                bus_if.sl_assert_en = 1'b0;
                bus_if.bl_assert_en = 1'b0;
            end else begin
                if (bus_if.work_en) cnt = 0;
                else if (cnt >= 0) cnt = cnt + 1;
                if (bus_if.op_down) begin
                    cnt = -1;
                    bus_if.sl_assert_en = 1'b0;
                    bus_if.bl_assert_en = 1'b0;
                end else if (cnt >= 0) begin
                    if (drop_dly >= 0 && cnt >= drop_dly) begin
                        bus_if.sl_assert_en = 1'b0;
                        bus_if.bl_assert_en = 1'b0;
                    end else begin
                        if (sl_dly >= 0 && cnt >= sl_dly) bus_if.sl_assert_en = 1'b1;
                        if (bl_dly >= 0 && cnt >= bl_dly) bus_if.bl_assert_en = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of one operation from the command rules.
    function automatic void model(input bit wr, input int sld, input int bld,
                                  output int dur, output int pl, output bit to);
        int m;
        dur = ARM + 1; pl = 0; to = 1'b1;
        if (!wr) begin
            dur = 1 + RD; pl = RD; to = 1'b0;
        end else if (sld >= 0 && bld >= 0) begin
            m = (sld > bld) ? sld : bld;
            if (m < 1) m = 1;
            if (m <= ARM) begin
                dur = m + 1 + WR; pl = WR; to = 1'b0;
            end
        end
    endfunction

    task automatic push_cmd(input bit wr, input bit st, input bit [4:0] sl, input bit [4:0] wl, input bit acc);
        @(negedge clk);
        bus_if.cmd_valid   = 1'b1;
        bus_if.cmd_write   = wr;
        bus_if.cmd_set     = st;
        bus_if.cmd_sl_addr = sl;
        bus_if.cmd_wl_addr = wl;
        chk("cmd_ready", bus_if.cmd_ready, acc);
        @(posedge clk);
        if (acc) exp_q.push_back('{wr, st, sl, wl});
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic check_next(input int sld, input int bld, input string tag);
        we_t w; dn_t d; cmd_t c; int edur; int epl; bit eto; int n;
        n = 0;
        while (done_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_op_seen"}, (done_q.size() > 0 && we_q.size() > 0 && exp_q.size() > 0), 1);
        if (done_q.size() == 0 || we_q.size() == 0 || exp_q.size() == 0) return;
        w = we_q.pop_front();
        d = done_q.pop_front();
        c = exp_q.pop_front();
        model(c.wr, sld, bld, edur, epl, eto);
        err_model = err_model | eto;
        chk({tag, "_work_mode"}, w.wm, c.wr);
        chk({tag, "_op_mode"}, w.om, c.st);
        chk({tag, "_sl"}, w.sl, c.sl);
        chk({tag, "_wl"}, w.wl, c.wl);
        chk({tag, "_hold"}, {d.wm, d.om, d.sl, d.wl}, {c.wr, c.st, c.sl, c.wl});
        chk({tag, "_dur"}, d.cyc - w.cyc, edur);
        chk({tag, "_plen"}, d.plen, epl);
        if (epl > 0) chk({tag, "_pstart"}, d.pstart - w.cyc, edur - epl);
        chk({tag, "_err"}, d.err, err_model);
        if (last_done >= 0) chk({tag, "_gap"}, (w.cyc - last_done >= 2), 1);
        last_done = d.cyc;
    endtask

    initial begin
        int n;
        int sld;
        int bld;
        rst_n = 1'b0;
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_write   = 1'b0;
        bus_if.cmd_set     = 1'b0;
        bus_if.cmd_sl_addr = 5'd0;
        bus_if.cmd_wl_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bus_if.work_en, bus_if.wl_pulse_en, bus_if.op_down, bus_if.busy,
                            bus_if.err_timeout, bus_if.work_mode, bus_if.op_mode}, 0);
        chk("rst_addrs", {bus_if.sl_addr_in, bus_if.wl_addr}, 0);
        chk("rst_ready", bus_if.cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Write set, drivers up 11 cycles after work_en.
        sl_dly = 11; bl_dly = 11;
        push_cmd(1'b1, 1'b1, 5'd5, 5'd3, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "wr_set");

        // Read never waits on the drivers.
        sl_dly = -1; bl_dly = -1;
        push_cmd(1'b0, 1'b0, 5'd0, 5'd7, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "read");

        // SL first, BL three cycles later.
        sl_dly = 2; bl_dly = 5;
        push_cmd(1'b1, 1'b0, 5'd9, 5'd17, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "stagger");

        // Drivers drop mid-pulse: pulse keeps its full width.
        sl_dly = 1; bl_dly = 1; drop_dly = 6;
        push_cmd(1'b1, 1'b1, 5'd31, 5'd0, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "drop");
        drop_dly = -1;

        // Fill the queue while a read runs: four accepted, fifth refused.
        push_cmd(1'b0, 1'b1, 5'd1, 5'd2, 1'b1);
        release_bus();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++)
            push_cmd(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), i < DEPTH);
        release_bus();
        chk("full_ready", bus_if.cmd_ready, 0);
        chk("full_busy", bus_if.busy, 1);
        for (int i = 0; i < 5; i++) check_next(sl_dly, bl_dly, "fifo_busy");

        // Burst from idle: the first command pops while the second pushes.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++)
            push_cmd(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), i <= DEPTH);
        release_bus();
        for (int i = 0; i < 5; i++) check_next(sl_dly, bl_dly, "fifo_idle");

        // BL never asserts: abort after the arm window, error sticks.
        sl_dly = 1; bl_dly = -1;
        push_cmd(1'b1, 1'b1, 5'd4, 5'd4, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "timeout");
        chk("err_sticky_idle", bus_if.err_timeout, 1);
        sl_dly = 1; bl_dly = 1;
        push_cmd(1'b1, 1'b0, 5'd6, 5'd8, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "after_timeout");

        // Reset in the middle of a pulse with commands still queued.
        push_cmd(1'b1, 1'b1, 5'd10, 5'd11, 1'b1);
        push_cmd(1'b0, 1'b1, 5'd12, 5'd13, 1'b1);
        push_cmd(1'b1, 1'b0, 5'd14, 5'd15, 1'b1);
        release_bus();
        n = 0;
        while (!bus_if.wl_pulse_en && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pulse_seen", bus_if.wl_pulse_en, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {bus_if.work_en, bus_if.wl_pulse_en, bus_if.op_down, bus_if.busy,
                               bus_if.err_timeout, bus_if.work_mode, bus_if.op_mode}, 0);
        chk("midrst_addrs", {bus_if.sl_addr_in, bus_if.wl_addr}, 0);
        chk("midrst_ready", bus_if.cmd_ready, 1);
        exp_q.delete(); we_q.delete(); done_q.delete();
        err_model = 1'b0;
        last_done = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("flush_busy", bus_if.busy, 0);
        chk("flush_no_work", we_q.size(), 0);
        push_cmd(1'b1, 1'b1, 5'd21, 5'd22, 1'b1);
        release_bus();
        check_next(sl_dly, bl_dly, "post_rst");

        // Randomized single operations, occasional arm timeouts.
        for (int i = 0; i < 14; i++) begin
            sld = $urandom_range(0, 20);
            bld = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 20);
            sl_dly = sld; bl_dly = bld;
            drop_dly = ($urandom_range(0, 2) == 0) ? (((sld > bld) ? sld : bld) + 3) : -1;
            push_cmd(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'b1);
            release_bus();
            check_next(sld, bld, "rand");
        end

        repeat (5) @(negedge clk);
        chk("end_no_extra_work", we_q.size(), 0);
        chk("end_no_extra_done", done_q.size(), 0);
        chk("end_idle", bus_if.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
